// File: rtl/stage_execute.sv
// Integer execute stage: single-cycle ALU plus a radix-16 iterative multiply.
// Work slot W holds the op being evaluated, output slot O holds the completed
// result for writeback. Bypass slot 0 mirrors W, bypass slot 1 mirrors O.
package stage_execute_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regaddr_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_MUL  = 4'd10
  } alu_mode_t;

  typedef struct packed {
    alu_mode_t alu_mode;
    regaddr_t  rd;
    logic      wb_en;
  } control_word_t;
endpackage

module stage_execute
  import stage_execute_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  control_word_t issue_cw_i,
  input  word_t         issue_alu_op1_i,
  input  word_t         issue_alu_op2_i,
  input  logic          issue_valid_i,
  output logic          issue_ready_o,
  output control_word_t exec_cw_o,
  output word_t         exec_result_o,
  output logic          exec_valid_o,
  input  logic          exec_ready_i,
  output regaddr_t [1:0] byp_addr_o,
  output word_t    [1:0] byp_data_o,
  output logic     [1:0] byp_valid_o,
  output logic     [1:0] byp_ready_o
);

  // Single-cycle ALU; MUL goes through the iterative path instead.
  function automatic word_t alu_eval(input alu_mode_t mode, input word_t a, input word_t b);
    word_t r;
    r = 32'd0;
    case (mode)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLT:  r = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: r = {31'd0, (a < b)};
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $signed(a) >>> b[4:0];
      default:  r = 32'd0;
    endcase
    return r;
  endfunction

  // Work slot W
  control_word_t w_cw_r;
  word_t         w_op1_r;
  word_t         w_op2_r;
  logic          w_valid_r;
  logic [2:0]    w_cnt_r;
  word_t         w_acc_r;

  // Output slot O
  control_word_t o_cw_r;
  word_t         o_result_r;
  logic          o_valid_r;

  logic [3:0] mul_nib_s;
  word_t      mul_term_s;
  word_t      w_result_s;
  logic       w_is_mul_s;
  logic       w_done_s;
  logic       advance_s;
  logic       issue_ready_s;
  logic       issue_fire_s;

  // Datapath for W and the slot-to-slot handshake decisions.
  always_comb begin
    mul_nib_s  = w_op2_r[{w_cnt_r, 2'b00} +: 4];
    mul_term_s = (w_op1_r * {28'd0, mul_nib_s}) << {w_cnt_r, 2'b00};
    w_is_mul_s = (w_cw_r.alu_mode == ALU_MUL);
    if (w_is_mul_s) begin
      // Final step folds the last partial product in combinationally.
      w_result_s = w_acc_r + mul_term_s;
    end else begin
      w_result_s = alu_eval(w_cw_r.alu_mode, w_op1_r, w_op2_r);
    end
    w_done_s      = w_valid_r && (!w_is_mul_s || (w_cnt_r == 3'd7));
    advance_s     = w_done_s && (!o_valid_r || exec_ready_i);
    issue_ready_s = !w_valid_r || advance_s;
    issue_fire_s  = issue_valid_i && issue_ready_s;
  end

  // W register: issue load wins, then advance clears, else multiply steps.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_cw_r    <= '0;
      w_op1_r   <= 32'd0;
      w_op2_r   <= 32'd0;
      w_valid_r <= 1'b0;
      w_cnt_r   <= 3'd0;
      w_acc_r   <= 32'd0;
    end else if (issue_fire_s) begin
      w_cw_r    <= issue_cw_i;
      w_op1_r   <= issue_alu_op1_i;
      w_op2_r   <= issue_alu_op2_i;
      w_valid_r <= 1'b1;
      w_cnt_r   <= 3'd0;
      w_acc_r   <= 32'd0;
    end else if (advance_s) begin
      w_valid_r <= 1'b0;
    end else if (w_valid_r && w_is_mul_s && (w_cnt_r != 3'd7)) begin
      w_cnt_r <= w_cnt_r + 3'd1;
      w_acc_r <= w_acc_r + mul_term_s;
    end
  end

  // O register: reload from W wins over unload by writeback.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      o_cw_r     <= '0;
      o_result_r <= 32'd0;
      o_valid_r  <= 1'b0;
    end else if (advance_s) begin
      o_cw_r     <= w_cw_r;
      o_result_r <= w_result_s;
      o_valid_r  <= 1'b1;
    end else if (o_valid_r && exec_ready_i) begin
      o_valid_r <= 1'b0;
    end
  end

  assign issue_ready_o = issue_ready_s;
  assign exec_cw_o     = o_cw_r;
  assign exec_result_o = o_result_r;
  assign exec_valid_o  = o_valid_r;

  assign byp_addr_o  = {o_cw_r.rd, w_cw_r.rd};
  assign byp_data_o  = {o_result_r, w_result_s};
  assign byp_valid_o = {o_valid_r && o_cw_r.wb_en && (o_cw_r.rd != 5'd0),
                        w_valid_r && w_cw_r.wb_en && (w_cw_r.rd != 5'd0)};
  assign byp_ready_o = {1'b1, w_done_s};

endmodule

// File: tb/tb_stage_execute.sv
// Self-checking bench for stage_execute: directed scenarios plus a randomized
// run scored against an in-order queue of arithmetically computed results.
module tb_stage_execute;
  import stage_execute_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  control_word_t issue_cw;
  word_t         op1;
  word_t         op2;
  logic          issue_valid;
  logic          issue_ready;
  control_word_t exec_cw;
  word_t         exec_result;
  logic          exec_valid;
  logic          exec_ready;
  regaddr_t [1:0] byp_addr;
  word_t    [1:0] byp_data;
  logic     [1:0] byp_valid;
  logic     [1:0] byp_ready;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { control_word_t cw; word_t res; } exp_t;

  stage_execute dut (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_cw_i(issue_cw), .issue_alu_op1_i(op1), .issue_alu_op2_i(op2),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .exec_cw_o(exec_cw), .exec_result_o(exec_result),
    .exec_valid_o(exec_valid), .exec_ready_i(exec_ready),
    .byp_addr_o(byp_addr), .byp_data_o(byp_data),
    .byp_valid_o(byp_valid), .byp_ready_o(byp_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: results computed straight from the operation definitions.
  function automatic word_t ref_result(input alu_mode_t m, input word_t a, input word_t b);
    longint unsigned p;
    word_t r;
    int sh;
    sh = int'(b[4:0]);
    case (m)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  r = a << sh;
      ALU_SRL:  r = a >> sh;
      ALU_SRA:  r = (a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'd0);
      ALU_MUL:  begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      default:  r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic control_word_t mk_cw(input alu_mode_t m, input int rd, input logic wb);
    control_word_t c;
    c.alu_mode = m;
    c.rd       = regaddr_t'(rd);
    c.wb_en    = wb;
    return c;
  endfunction

  function automatic word_t rnd_word();
    word_t w;
    case ($urandom_range(0, 5))
      0: w = 32'd0;
      1: w = 32'hFFFFFFFF;
      2: w = 32'h80000000;
      3: w = word_t'($urandom_range(0, 40));
      default: w = $urandom;
    endcase
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    issue_valid = 1'b0;
    exec_ready  = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; issue_valid = 1'b0; exec_ready = 1'b1;
    issue_cw = '0; op1 = 32'd0; op2 = 32'd0;
    tick(); tick();
    n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL reset_issue_ready: got %b want 1", issue_ready); end
    n_cmp++; if (exec_valid !== 1'b0) begin n_err++; $display("FAIL reset_exec_valid: got %b want 0", exec_valid); end
    n_cmp++; if (byp_valid !== 2'b00) begin n_err++; $display("FAIL reset_byp_valid: got %b want 00", byp_valid); end
    n_cmp++; if (byp_ready !== 2'b10) begin n_err++; $display("FAIL reset_byp_ready: got %b want 10", byp_ready); end
    n_cmp++; if (exec_result !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h want 0", exec_result); end
    n_cmp++; if (exec_cw !== control_word_t'(0)) begin n_err++; $display("FAIL reset_cw: got %h want 0", exec_cw); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add_bypass();
    exec_ready = 1'b1;
    issue_cw = mk_cw(ALU_ADD, 3, 1'b1); op1 = 32'd5; op2 = 32'd7; issue_valid = 1'b1;
    #1;
    n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL add_issue_ready: got %b want 1", issue_ready); end
    tick(); issue_valid = 1'b0; #1;
    n_cmp++; if (byp_valid[0] !== 1'b1 || byp_ready[0] !== 1'b1) begin n_err++; $display("FAIL add_byp0_flags: got v=%b r=%b want 1 1", byp_valid[0], byp_ready[0]); end
    n_cmp++; if (byp_data[0] !== 32'd12 || byp_addr[0] !== 5'd3) begin n_err++; $display("FAIL add_byp0_data: got %h@%0d want 0000000c@3", byp_data[0], byp_addr[0]); end
    n_cmp++; if (exec_valid !== 1'b0) begin n_err++; $display("FAIL add_early_valid: got %b want 0", exec_valid); end
    tick(); #1;
    n_cmp++; if (exec_valid !== 1'b1 || exec_result !== 32'd12) begin n_err++; $display("FAIL add_result: got v=%b %h want v=1 0000000c", exec_valid, exec_result); end
    n_cmp++; if (byp_valid !== 2'b10 || exec_cw.rd !== 5'd3) begin n_err++; $display("FAIL add_byp1: got bv=%b rd=%0d want 10 rd=3", byp_valid, exec_cw.rd); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    exec_ready = 1'b1;
    issue_cw = mk_cw(ALU_SUB, 1, 1'b1); op1 = 32'd3; op2 = 32'd5; issue_valid = 1'b1;
    tick();
    issue_cw = mk_cw(ALU_SRA, 2, 1'b1); op1 = 32'h80000000; op2 = 32'd4;
    #1;
    n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b want 1", issue_ready); end
    tick(); issue_valid = 1'b0; #1;
    n_cmp++; if (exec_valid !== 1'b1 || exec_result !== 32'hFFFFFFFE) begin n_err++; $display("FAIL b2b_sub: got v=%b %h want v=1 fffffffe", exec_valid, exec_result); end
    tick(); #1;
    n_cmp++; if (exec_valid !== 1'b1 || exec_result !== 32'hF8000000) begin n_err++; $display("FAIL b2b_sra: got v=%b %h want v=1 f8000000", exec_valid, exec_result); end
    idle(2);
  endtask

  task automatic test_mul();
    exec_ready = 1'b1;
    issue_cw = mk_cw(ALU_MUL, 5, 1'b1); op1 = 32'hFFFFFFFF; op2 = 32'd3; issue_valid = 1'b1;
    tick(); issue_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      #1;
      n_cmp++; if (byp_valid[0] !== 1'b1 || byp_ready[0] !== 1'b0 || issue_ready !== 1'b0 || exec_valid !== 1'b0) begin
        n_err++; $display("FAIL mul_busy_%0d: got bv0=%b br0=%b ir=%b ev=%b want 1 0 0 0", k, byp_valid[0], byp_ready[0], issue_ready, exec_valid);
      end
      tick();
    end
    #1;
    n_cmp++; if (byp_ready[0] !== 1'b1 || byp_data[0] !== 32'hFFFFFFFD || issue_ready !== 1'b1) begin
      n_err++; $display("FAIL mul_done: got br0=%b %h ir=%b want 1 fffffffd 1", byp_ready[0], byp_data[0], issue_ready);
    end
    tick(); #1;
    n_cmp++; if (exec_valid !== 1'b1 || exec_result !== 32'hFFFFFFFD || exec_cw.rd !== 5'd5) begin
      n_err++; $display("FAIL mul_result: got v=%b %h rd=%0d want v=1 fffffffd rd=5", exec_valid, exec_result, exec_cw.rd);
    end
    idle(2);
  endtask

  task automatic test_backpressure();
    word_t got[$];
    exec_ready = 1'b0;
    issue_cw = mk_cw(ALU_ADD, 1, 1'b1); op1 = 32'd10; op2 = 32'd1; issue_valid = 1'b1;
    tick();
    issue_cw = mk_cw(ALU_ADD, 2, 1'b1); op1 = 32'd20; op2 = 32'd2;
    tick();
    issue_cw = mk_cw(ALU_ADD, 3, 1'b1); op1 = 32'd30; op2 = 32'd3;
    #1;
    n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_low: got %b want 0", issue_ready); end
    tick();
    n_cmp++; if (exec_valid !== 1'b1 || exec_result !== 32'd11 || issue_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_hold: got v=%b %h ir=%b want v=1 0000000b ir=0", exec_valid, exec_result, issue_ready);
    end
    exec_ready = 1'b1;
    #1;
    n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", issue_ready); end
    for (int k = 0; k < 6; k++) begin
      if (exec_valid) got.push_back(exec_result);
      tick(); issue_valid = 1'b0; #1;
    end
    n_cmp++; if (got.size() !== 3) begin n_err++; $display("FAIL bp_count: got %0d want 3", got.size()); end
    else begin
      n_cmp++; if (got[0] !== 32'd11 || got[1] !== 32'd22 || got[2] !== 32'd33) begin
        n_err++; $display("FAIL bp_order: got %h %h %h want 0000000b 00000016 00000021", got[0], got[1], got[2]);
      end
    end
    idle(2);
  endtask

  task automatic test_no_writeback();
    exec_ready = 1'b1;
    issue_cw = mk_cw(ALU_ADD, 0, 1'b1); op1 = 32'd1; op2 = 32'd2; issue_valid = 1'b1;
    tick();
    issue_cw = mk_cw(ALU_ADD, 4, 1'b0); op1 = 32'd3; op2 = 32'd4;
    #1;
    n_cmp++; if (byp_valid[0] !== 1'b0 || byp_ready[0] !== 1'b1) begin n_err++; $display("FAIL nowb_rd0_slot0: got v=%b r=%b want 0 1", byp_valid[0], byp_ready[0]); end
    tick(); issue_valid = 1'b0; #1;
    n_cmp++; if (byp_valid !== 2'b00 || exec_valid !== 1'b1 || exec_result !== 32'd3) begin
      n_err++; $display("FAIL nowb_first: got bv=%b ev=%b %h want 00 1 00000003", byp_valid, exec_valid, exec_result);
    end
    tick(); #1;
    n_cmp++; if (byp_valid !== 2'b00 || exec_valid !== 1'b1 || exec_result !== 32'd7) begin
      n_err++; $display("FAIL nowb_second: got bv=%b ev=%b %h want 00 1 00000007", byp_valid, exec_valid, exec_result);
    end
    idle(2);
  endtask

  task automatic test_reset_mid_mul();
    exec_ready = 1'b1;
    issue_cw = mk_cw(ALU_MUL, 7, 1'b1); op1 = 32'h12345678; op2 = 32'h9ABCDEF1; issue_valid = 1'b1;
    tick(); issue_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (exec_valid !== 1'b0 || byp_valid !== 2'b00 || byp_ready !== 2'b10 || issue_ready !== 1'b1) begin
      n_err++; $display("FAIL rstmul_outputs: got ev=%b bv=%b br=%b ir=%b want 0 00 10 1", exec_valid, byp_valid, byp_ready, issue_ready);
    end
    n_cmp++; if (dut.w_cnt_r !== 3'd0) begin n_err++; $display("FAIL rstmul_counter: got %0d want 0", dut.w_cnt_r); end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      n_cmp++; if (exec_valid !== 1'b0 || issue_ready !== 1'b1) begin
        n_err++; $display("FAIL rstmul_stale_%0d: got ev=%b ir=%b want 0 1", k, exec_valid, issue_ready);
      end
      tick();
    end
    issue_cw = mk_cw(ALU_XOR, 9, 1'b1); op1 = 32'hF0F0F0F0; op2 = 32'h0FF00FF0; issue_valid = 1'b1;
    tick(); issue_valid = 1'b0; tick(); #1;
    n_cmp++; if (exec_valid !== 1'b1 || exec_result !== 32'hFF00FF00) begin
      n_err++; $display("FAIL rstmul_recover: got v=%b %h want v=1 ff00ff00", exec_valid, exec_result);
    end
    idle(2);
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    exp_t f;
    logic hs;
    issue_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!issue_valid && ($urandom_range(0, 3) != 0)) begin
        issue_cw = mk_cw(alu_mode_t'($urandom_range(0, 10)), int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        op1 = rnd_word(); op2 = rnd_word(); issue_valid = 1'b1;
      end
      exec_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (exec_valid) begin
        n_cmp++; if (byp_valid[1] !== (exec_cw.wb_en && (exec_cw.rd != 5'd0)) || byp_addr[1] !== exec_cw.rd || byp_data[1] !== exec_result) begin
          n_err++; $display("FAIL rnd_byp1: got v=%b a=%0d d=%h for cw=%h res=%h", byp_valid[1], byp_addr[1], byp_data[1], exec_cw, exec_result);
        end
      end
      if (exec_valid && exec_ready) begin
        n_cmp++;
        if (q.size() == 0) begin n_err++; $display("FAIL rnd_spurious: got output %h want none", exec_result); end
        else begin
          f = q.pop_front();
          if (exec_cw !== f.cw || exec_result !== f.res) begin
            n_err++; $display("FAIL rnd_result: got cw=%h %h want cw=%h %h", exec_cw, exec_result, f.cw, f.res);
          end
        end
      end
      hs = issue_valid && issue_ready;
      if (hs) begin
        e.cw = issue_cw; e.res = ref_result(issue_cw.alu_mode, op1, op2);
        q.push_back(e);
      end
      tick();
      if (hs) issue_valid = 1'b0;
    end
    issue_valid = 1'b0; exec_ready = 1'b1;
    for (int c = 0; c < 40 && q.size() > 0; c++) begin
      #1;
      if (exec_valid) begin
        f = q.pop_front();
        n_cmp++; if (exec_cw !== f.cw || exec_result !== f.res) begin
          n_err++; $display("FAIL rnd_drain: got cw=%h %h want cw=%h %h", exec_cw, exec_result, f.cw, f.res);
        end
      end
      tick();
    end
    n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL rnd_leftover: got %0d pending want 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_add_bypass();
    test_back_to_back();
    test_mul();
    test_backpressure();
    test_no_writeback();
    test_reset_mid_mul();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
